// File: rtl/td4_out_uart.sv
// Logs the td4 OUT port: each value change is queued in a small FIFO and
// sent as one uppercase ASCII hex character on an 8N1 UART line.
module td4_out_uart #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_AW      = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic [3:0] OUT_IN,
  output logic       TX,
  output logic       BUSY,
  output logic       OVERFLOW
);

  localparam int DEPTH = 1 << FIFO_AW;
  localparam int BW    = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0]      BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0]   DEPTH_C   = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    if (n < 4'd10) begin
      return 8'h30 + {4'h0, n};
    end else begin
      return 8'h37 + {4'h0, n};
    end
  endfunction

  state_t             state_q, state_d;
  logic [BW-1:0]      baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [7:0]         shift_q, shift_d;
  logic [3:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]   count_q, count_d;
  logic [3:0]         last_q;
  logic               tx_q, tx_d, busy_q, busy_d, ovf_q, ovf_d;

  logic push_req_s, push_ok_s, pop_s, baud_done_s, fifo_ne_s;

  assign baud_done_s = (baud_q == BAUD_LAST);
  assign fifo_ne_s   = (count_q != '0);
  assign push_req_s  = (OUT_IN != last_q);
  assign pop_s       = fifo_ne_s &&
                       ((state_q == S_IDLE) || ((state_q == S_STOP) && baud_done_s));
  // A push into a full FIFO still fits when the reader frees a slot on the same edge.
  assign push_ok_s   = push_req_s && ((count_q < DEPTH_C) || pop_s);

  // FIFO pointer, occupancy and overflow bookkeeping
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (push_ok_s) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (push_req_s && !push_ok_s) begin
      ovf_d = 1'b1;
    end else begin
      ovf_d = ovf_q;
    end
  end

  // Next-state logic for the frame sequencer and its baud/bit counters
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    case (state_q)
      S_IDLE: begin
        baud_d = '0;
        if (pop_s) begin
          state_d = S_START;
          bit_d   = 3'd0;
          shift_d = hex_ascii(mem_q[rd_ptr_q]);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_START: begin
        if (baud_done_s) begin
          state_d = S_DATA;
          baud_d  = '0;
          bit_d   = 3'd0;
        end else begin
          state_d = S_START;
        end
      end
      S_DATA: begin
        if (baud_done_s) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            state_d = S_DATA;
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          state_d = S_DATA;
        end
      end
      S_STOP: begin
        if (baud_done_s) begin
          baud_d = '0;
          if (pop_s) begin
            state_d = S_START;
            bit_d   = 3'd0;
            shift_d = hex_ascii(mem_q[rd_ptr_q]);
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          state_d = S_STOP;
        end
      end
      default: begin
        state_d = S_IDLE;
        baud_d  = '0;
      end
    endcase
  end

  // Output decode from next state so TX and BUSY come straight from flops
  always_comb begin
    tx_d   = 1'b1;
    busy_d = (state_d != S_IDLE) || (count_d != '0);
    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
  end

  // State, counters, pointers and registered outputs
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      bit_q    <= 3'd0;
      shift_q  <= 8'h00;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      last_q   <= 4'h0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      last_q   <= OUT_IN;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
    end
  end

  // FIFO storage; stale entries are harmless since count gates every read
  always_ff @(posedge CLK) begin
    if (!RESET && push_ok_s) begin
      mem_q[wr_ptr_q] <= OUT_IN;
    end else begin
      mem_q[wr_ptr_q] <= mem_q[wr_ptr_q];
    end
  end

  assign TX       = tx_q;
  assign BUSY     = busy_q;
  assign OVERFLOW = ovf_q;

endmodule
